// File: rtl/mem_stage_banked_pkg.sv
// mem_pkg: shared types for the banked memory stage.
//   NOP_PAIR : instruction pair carried by every bubble
//   side_t   : instruction sideband that travels beside each access
//   BUBBLE   : the sideband value of an empty pipeline slot
package mem_pkg;

   localparam logic [63:0] NOP_PAIR = {3'b111, 29'b0, 3'b111, 29'b0};

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] inst;
      logic [4:0]  u_rt;
      logic        u_rt_flag;
      logic [31:0] l_tdata;
      logic [4:0]  l_rt;
      logic        l_rt_flag;
      logic        err;        // address was outside the banked space
   } side_t;

   localparam side_t BUBBLE = '{pc: 32'd0, inst: NOP_PAIR, u_rt: 5'd0, u_rt_flag: 1'b0,
                                l_tdata: 32'd0, l_rt: 5'd0, l_rt_flag: 1'b0, err: 1'b0};

endpackage

// File: rtl/mem_stage_banked_if.sv
// mem_stage_banked_if: EX-side request bus and WB-side response bus of the
// memory stage.
//   master : drives stall/flush and the access, observes the delayed outputs
//   slave  : the memory stage itself
interface mem_stage_banked_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
);
   logic                  stall;
   logic                  flush;
   logic [31:0]           pc;
   logic [63:0]           inst;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     dina;
   logic [DATA_W/8-1:0]   wea;
   logic [4:0]            u_rt;
   logic [4:0]            l_rt;
   logic                  u_rt_flag;
   logic                  l_rt_flag;
   logic [31:0]           l_tdata;

   logic [31:0]           pc_out;
   logic [63:0]           inst_out;
   logic [4:0]            u_rt_out;
   logic [4:0]            l_rt_out;
   logic                  u_rt_flag_out;
   logic                  l_rt_flag_out;
   logic [31:0]           l_tdata_out;
   logic [DATA_W-1:0]     mem_doutb;
   logic                  err_out;

   modport master (
      output stall, flush, pc, inst, addr, dina, wea, u_rt, l_rt, u_rt_flag, l_rt_flag, l_tdata,
      input  pc_out, inst_out, u_rt_out, l_rt_out, u_rt_flag_out, l_rt_flag_out, l_tdata_out,
             mem_doutb, err_out
   );

   modport slave (
      input  stall, flush, pc, inst, addr, dina, wea, u_rt, l_rt, u_rt_flag, l_rt_flag, l_tdata,
      output pc_out, inst_out, u_rt_out, l_rt_out, u_rt_flag_out, l_rt_flag_out, l_tdata_out,
             mem_doutb, err_out
   );
endinterface

// File: rtl/mem_stage_banked_bank.sv
// mem_bank: single-port write-first RAM with byte enables and a registered
// read port.
//   clk  : clock
//   en   : port enable; low freezes both the array and the read register
//   addr : word row
//   din  : write data
//   we   : byte write enables (zero = read only)
//   dout : registered read data; shows the merged word on a store
module mem_bank #(
   parameter int DATA_W = 64,
   parameter int AW     = 15
) (
   input  logic                clk,
   input  logic                en,
   input  logic [AW-1:0]       addr,
   input  logic [DATA_W-1:0]   din,
   input  logic [DATA_W/8-1:0] we,
   output logic [DATA_W-1:0]   dout
);
   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [2**AW];
   logic [DATA_W-1:0] dout_q;

   // NOTE: the array and its read register carry no reset so the block maps
   // onto a RAM macro; contents are only defined once written.
   // NOTE: clocked state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
               mem_q[addr][b*8 +: 8] <= din[b*8 +: 8];
               dout_q[b*8 +: 8]      <= din[b*8 +: 8];
            end else begin
               dout_q[b*8 +: 8]      <= mem_q[addr][b*8 +: 8];
            end
         end
      end
   end

   assign dout = dout_q;
endmodule

// File: rtl/mem_stage_banked.sv
// mem_stage_banked: data-memory stage. One access per cycle from EX goes to
// one of BANKS RAM banks; read data and the instruction sideband reach WB
// LAT accepted edges later.
//   clk  : clock, posedge only
//   rstn : asynchronous active-low reset
//   bus  : request (stall, flush, access, sideband) and WB response
module mem_stage_banked
   import mem_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int BANKS   = 8,
   parameter int BANK_AW = 15,
   parameter int ADDR_W  = 32,
   parameter int LAT     = 2
) (
   input  logic              clk,
   input  logic              rstn,
   mem_stage_banked_if.slave bus
);
   localparam int SEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int HI    = BANK_AW + $clog2(BANKS);   // first address bit above the banked space

   logic               accept;
   logic               in_range;
   logic [SEL_W-1:0]   bank_sel;
   side_t              in_side;
   logic [DATA_W-1:0]  rd_data [BANKS];

   side_t              stg_q  [LAT];
   side_t              stg_d  [LAT];
   logic [DATA_W-1:0]  data_q [LAT-1];
   logic [DATA_W-1:0]  data_d [LAT-1];
   logic [SEL_W-1:0]   bank_q;   // bank of the access in stage 1, steers the read mux
   logic [SEL_W-1:0]   bank_d;

   assign accept   = ~bus.stall & ~bus.flush;
   assign in_range = (bus.addr >> HI) == '0;

   if (BANKS > 1) begin : g_sel
      assign bank_sel = bus.addr[BANK_AW +: SEL_W];
   end else begin : g_one
      assign bank_sel = '0;
   end

   // All banks read every unstalled cycle; only the addressed bank may write.
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic [DATA_W/8-1:0] we_b;
      assign we_b = (accept && in_range && (bank_sel == SEL_W'(b))) ? bus.wea : '0;

      mem_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
         .clk  (clk),
         .en   (~bus.stall),
         .addr (bus.addr[BANK_AW-1:0]),
         .din  (bus.dina),
         .we   (we_b),
         .dout (rd_data[b])
      );
   end

   always_comb begin
      in_side           = BUBBLE;
      in_side.pc        = bus.pc;
      in_side.inst      = bus.inst;
      in_side.u_rt      = bus.u_rt;
      in_side.u_rt_flag = bus.u_rt_flag;
      in_side.l_tdata   = bus.l_tdata;
      in_side.l_rt      = bus.l_rt;
      in_side.l_rt_flag = bus.l_rt_flag;
      in_side.err       = ~in_range;
   end

   // Flush empties the sideband stages but leaves the data registers alone,
   // so mem_doutb keeps its last value.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      stg_d  = stg_q;
      data_d = data_q;
      bank_d = bank_q;
      if (bus.flush) begin
         for (int i = 0; i < LAT; i++) stg_d[i] = BUBBLE;
      end else if (!bus.stall) begin
         stg_d[0] = in_side;
         bank_d   = bank_sel;
         for (int i = 1; i < LAT; i++) stg_d[i] = stg_q[i-1];
         data_d[0] = stg_q[0].err ? '0 : rd_data[bank_q];
         for (int i = 1; i < LAT-1; i++) data_d[i] = data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < LAT; i++)   stg_q[i]  <= BUBBLE;
         for (int i = 0; i < LAT-1; i++) data_q[i] <= '0;
         bank_q <= '0;
      end else begin
         stg_q  <= stg_d;
         data_q <= data_d;
         bank_q <= bank_d;
      end
   end

   assign bus.pc_out        = stg_q[LAT-1].pc;
   assign bus.inst_out      = stg_q[LAT-1].inst;
   assign bus.u_rt_out      = stg_q[LAT-1].u_rt;
   assign bus.u_rt_flag_out = stg_q[LAT-1].u_rt_flag;
   assign bus.l_tdata_out   = stg_q[LAT-1].l_tdata;
   assign bus.l_rt_out      = stg_q[LAT-1].l_rt;
   assign bus.l_rt_flag_out = stg_q[LAT-1].l_rt_flag;
   assign bus.err_out       = stg_q[LAT-1].err;
   assign bus.mem_doutb     = data_q[LAT-2];
endmodule

// File: tb/tb_mem_stage_banked.sv
// tb_mem_stage_banked: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (word map + history of accepted
// accesses).
module tb_mem_stage_banked;
   import mem_pkg::*;

   localparam int DATA_W  = 64;
   localparam int BANKS   = 8;
   localparam int BANK_AW = 15;
   localparam int ADDR_W  = 32;
   localparam int LAT     = 2;
   localparam logic [31:0] SPAN = 32'h1 << (BANK_AW + $clog2(BANKS));

   typedef struct {
      logic [31:0] pc;
      logic [63:0] inst;
      logic [31:0] addr;
      logic [63:0] dina;
      logic [7:0]  wea;
      logic [4:0]  u_rt;
      logic [4:0]  l_rt;
      logic        uf;
      logic        lf;
      logic [31:0] l_tdata;
   } txn_t;

   typedef struct {
      bit          bubble;
      bit          known;
      logic [31:0] pc;
      logic [63:0] inst;
      logic [4:0]  u_rt;
      logic [4:0]  l_rt;
      logic        uf;
      logic        lf;
      logic [31:0] l_tdata;
      logic        err;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   mem_stage_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_stage_banked #(
      .DATA_W(DATA_W), .BANKS(BANKS), .BANK_AW(BANK_AW), .ADDR_W(ADDR_W), .LAT(LAT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   exp_t        hist[$];             // hist[0] = most recent accepted edge
   logic [63:0] mem_m [logic [31:0]];
   logic [63:0] exp_dout;
   bit          dout_valid;
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] pool [32];
   logic [31:0] rows [4] = '{32'h0, 32'h3, 32'h10, 32'h7FFF};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t bubble_e();
      exp_t e;
      e.bubble = 1'b1; e.known = 1'b0; e.pc = '0; e.inst = NOP_PAIR;
      e.u_rt = '0; e.l_rt = '0; e.uf = 1'b0; e.lf = 1'b0; e.l_tdata = '0;
      e.err = 1'b0; e.data = '0;
      return e;
   endfunction

   // Applies an accepted access to the word map and returns what WB must see.
   function automatic exp_t accept_model(input txn_t t);
      exp_t e;
      logic [63:0] w;
      e.bubble = 1'b0; e.known = 1'b1; e.pc = t.pc; e.inst = t.inst;
      e.u_rt = t.u_rt; e.l_rt = t.l_rt; e.uf = t.uf; e.lf = t.lf; e.l_tdata = t.l_tdata;
      e.err = (t.addr >= SPAN);
      e.data = '0;
      if (!e.err) begin
         if (mem_m.exists(t.addr)) begin
            w = mem_m[t.addr];
            for (int b = 0; b < 8; b++) if (t.wea[b]) w[b*8 +: 8] = t.dina[b*8 +: 8];
            mem_m[t.addr] = w;
            e.data = w;
         end else if (t.wea == 8'hFF) begin
            mem_m[t.addr] = t.dina;
            e.data = t.dina;
         end else begin
            e.known = 1'b0;
         end
      end
      return e;
   endfunction

   function automatic txn_t mk(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] wea);
      txn_t t;
      t.pc = $urandom; t.inst = {$urandom, $urandom}; t.addr = addr; t.dina = data; t.wea = wea;
      t.u_rt = 5'($urandom_range(0, 31)); t.l_rt = 5'($urandom_range(0, 31));
      t.uf = 1'($urandom_range(0, 1)); t.lf = 1'($urandom_range(0, 1)); t.l_tdata = $urandom;
      return t;
   endfunction

   function automatic txn_t idle_t();
      txn_t t;
      t.pc = '0; t.inst = NOP_PAIR; t.addr = '0; t.dina = '0; t.wea = '0;
      t.u_rt = '0; t.l_rt = '0; t.uf = 1'b0; t.lf = 1'b0; t.l_tdata = '0;
      return t;
   endfunction

   task automatic drive(input bit st, input bit fl, input txn_t t);
      bus.stall = st; bus.flush = fl; bus.pc = t.pc; bus.inst = t.inst; bus.addr = t.addr;
      bus.dina = t.dina; bus.wea = t.wea; bus.u_rt = t.u_rt; bus.l_rt = t.l_rt;
      bus.u_rt_flag = t.uf; bus.l_rt_flag = t.lf; bus.l_tdata = t.l_tdata;
   endtask

   task automatic compare_outputs();
      exp_t o;
      o = hist[LAT-1];
      check("pc_out",        64'(bus.pc_out),        64'(o.pc));
      check("inst_out",      bus.inst_out,           o.inst);
      check("u_rt_out",      64'(bus.u_rt_out),      64'(o.u_rt));
      check("l_rt_out",      64'(bus.l_rt_out),      64'(o.l_rt));
      check("u_rt_flag_out", 64'(bus.u_rt_flag_out), 64'(o.uf));
      check("l_rt_flag_out", 64'(bus.l_rt_flag_out), 64'(o.lf));
      check("l_tdata_out",   64'(bus.l_tdata_out),   64'(o.l_tdata));
      check("err_out",       64'(bus.err_out),       64'(o.err));
      if (dout_valid) check("mem_doutb", bus.mem_doutb, exp_dout);
   endtask

   task automatic step(input bit st, input bit fl, input txn_t t);
      drive(st, fl, t);
      @(posedge clk);
      if (fl) begin
         foreach (hist[i]) hist[i] = bubble_e();
      end else if (!st) begin
         hist.push_front(accept_model(t));
         void'(hist.pop_back());
         if (hist[LAT-1].bubble || !hist[LAT-1].known) begin
            dout_valid = 1'b0;
         end else begin
            dout_valid = 1'b1;
            exp_dout   = hist[LAT-1].data;
         end
      end
      #1;
      compare_outputs();
   endtask

   initial begin
      int r;
      bit st, fl;
      logic [31:0] a;
      logic [7:0]  we;

      for (int i = 0; i < 32; i++) pool[i] = (32'(i % 8) << BANK_AW) | rows[i / 8];
      for (int i = 0; i < LAT; i++) hist.push_back(bubble_e());
      exp_dout   = '0;
      dout_valid = 1'b1;

      // reset state
      rstn = 1'b0;
      drive(1'b0, 1'b0, idle_t());
      repeat (2) @(posedge clk);
      #1;
      compare_outputs();
      rstn = 1'b1;

      // idle
      repeat (10) step(1'b0, 1'b0, idle_t());

      // preload every pool word so later reads are defined
      for (int i = 0; i < 32; i++) step(1'b0, 1'b0, mk(pool[i], {$urandom, $urandom}, 8'hFF));

      // store then load across banks
      step(1'b0, 1'b0, mk(32'h8003, 64'h1122334455667788, 8'hFF));
      step(1'b0, 1'b0, mk(32'h8003, '0, 8'h00));
      step(1'b0, 1'b0, mk(32'h0003, '0, 8'h00));
      check("load_8003", bus.mem_doutb, 64'h1122334455667788);
      step(1'b0, 1'b0, idle_t());

      // byte merge
      step(1'b0, 1'b0, mk(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF));
      step(1'b0, 1'b0, mk(32'h10, 64'h0, 8'h0F));
      step(1'b0, 1'b0, mk(32'h10, '0, 8'h00));
      step(1'b0, 1'b0, idle_t());
      check("byte_merge", bus.mem_doutb, 64'hFFFF_FFFF_0000_0000);

      // stall with a load in flight and a store offered during the stall
      step(1'b0, 1'b0, mk(32'h8003, '0, 8'h00));
      repeat (3) step(1'b1, 1'b0, mk(32'h8003, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF));
      step(1'b0, 1'b0, idle_t());
      step(1'b0, 1'b0, mk(32'h8003, '0, 8'h00));
      step(1'b0, 1'b0, idle_t());
      check("stall_nowrite", bus.mem_doutb, 64'h1122334455667788);

      // flush with a store in stage 1 and a store at the input
      step(1'b0, 1'b0, mk(32'h10, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF));
      step(1'b0, 1'b1, mk(32'h0, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF));
      step(1'b0, 1'b0, mk(32'h0, '0, 8'h00));
      step(1'b0, 1'b0, idle_t());

      // out-of-range store, then row 0 of bank 0 must be untouched
      step(1'b0, 1'b0, mk(32'h0004_0000, 64'h0123_4567_89AB_CDEF, 8'hFF));
      step(1'b0, 1'b0, mk(32'h0, '0, 8'h00));
      check("oor_err", 64'(bus.err_out), 64'd1);
      check("oor_data", bus.mem_doutb, 64'd0);
      step(1'b0, 1'b0, idle_t());

      // random traffic
      repeat (400) begin
         r  = $urandom_range(0, 99);
         st = ($urandom_range(0, 9) == 0);
         fl = (r < 5);
         a  = pool[$urandom_range(0, 31)];
         if ($urandom_range(0, 19) == 0) a = a | (32'h1 << (BANK_AW + 3 + $urandom_range(0, 13)));
         r  = $urandom_range(0, 9);
         we = (r < 3) ? 8'($urandom) : (r < 6) ? 8'hFF : 8'h00;
         step(st, fl, mk(a, {$urandom, $urandom}, we));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
